// File: rtl/noc_pe.sv
// Compute endpoint on a router's local port: accumulates each accepted payload
// and returns {PE_ADDR, src, acc} to the sender one clock after acceptance.
module noc_pe #(
    parameter int          DATA_WIDTH = 16,
    parameter int          ADDR_WIDTH = 2,
    parameter int unsigned PE_ADDR    = 0,
    localparam int         PW         = DATA_WIDTH + 2 * ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid_from_router,
    input  logic [PW-1:0] i_data_from_router,
    output logic          o_valid_to_router,
    output logic [PW-1:0] o_data_to_router,
    output logic [1:0]    dbg_state_o
);

    // Handshake: a packet is taken on the first clock where the valid level is
    // seen high after being low while IDLE; there is no ready, so rises seen
    // while busy are dropped and the response must be sunk in its single
    // valid cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SEND    = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PE_ADDR_L = ADDR_WIDTH'(PE_ADDR);

    state_t                  state_q;
    logic                    prev_valid_q;
    logic [DATA_WIDTH-1:0]   acc_q;
    logic [DATA_WIDTH-1:0]   acc_d;
    logic [ADDR_WIDTH-1:0]   src_q;
    logic [DATA_WIDTH-1:0]   payload_q;
    logic                    o_valid_q;
    logic [PW-1:0]           o_data_q;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   in_src;
    logic [DATA_WIDTH-1:0]   in_payload;
    logic                    unused_dst;

    assign in_src     = i_data_from_router[PW-1 -: ADDR_WIDTH];
    assign in_payload = i_data_from_router[DATA_WIDTH-1:0];
    // The router has already delivered this packet here; dst carries no meaning.
    assign unused_dst = ^i_data_from_router[DATA_WIDTH +: ADDR_WIDTH];

    assign accept = i_valid_from_router && !prev_valid_q && (state_q == IDLE);
    assign acc_d  = acc_q + payload_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_valid_q <= 1'b0;
            acc_q        <= '0;
            src_q        <= '0;
            payload_q    <= '0;
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
        end else begin
            prev_valid_q <= i_valid_from_router;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        src_q     <= in_src;
                        payload_q <= in_payload;
                        state_q   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc_q     <= acc_d;
                    o_data_q  <= {PE_ADDR_L, src_q, acc_d};
                    o_valid_q <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    o_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    o_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_valid_to_router = o_valid_q;
    assign o_data_to_router  = o_data_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_noc_pe.sv
// Directed bench for noc_pe: reset, accumulate, wrap, busy-drop and
// mid-operation reset, with hand-computed response packets.
module tb_noc_pe;

    localparam int PW = 20;

    logic          clk;
    logic          rst;
    logic          valid;
    logic [PW-1:0] data;
    logic          o_valid;
    logic [PW-1:0] o_data;
    logic [1:0]    dbg_state;

    int n_checks;
    int n_fail;
    int pulse_cnt;
    int pulses_before;

    noc_pe #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .PE_ADDR(0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_valid_from_router (valid),
        .i_data_from_router  (data),
        .o_valid_to_router   (o_valid),
        .o_data_to_router    (o_data),
        .dbg_state_o         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (o_valid === 1'b1) pulse_cnt++;
    endtask

    task automatic send_pkt(input string tag, input logic [PW-1:0] pkt, input logic [PW-1:0] exp);
        valid = 1'b1;
        data  = pkt;
        step();
        check({tag, "_t0_valid"}, 32'(o_valid), 32'd0);
        step();
        check({tag, "_t1_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_t1_data"}, 32'(o_data), 32'(exp));
        valid = 1'b0;
        step();
        check({tag, "_t2_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_t2_hold"}, 32'(o_data), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pulse_cnt = 0;
        rst       = 1'b1;
        valid     = 1'b0;
        data      = '0;

        // Reset values
        do_reset();
        pulse_cnt = 0;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'h00000);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (3) step();
        check("rst_no_pulse", 32'(pulse_cnt), 32'd0);

        // Single packet, valid held for 5 sampled edges
        valid = 1'b1;
        data  = 20'h65A5A;
        step();
        check("p1_t0_valid", 32'(o_valid), 32'd0);
        check("p1_t0_state", 32'(dbg_state), 32'd1);
        step();
        check("p1_t1_valid", 32'(o_valid), 32'd1);
        check("p1_t1_data", 32'(o_data), 32'h15A5A);
        step();
        check("p1_t2_valid", 32'(o_valid), 32'd0);
        check("p1_t2_state", 32'(dbg_state), 32'd0);
        step();
        step();
        valid = 1'b0;
        step();
        check("p1_one_pulse", 32'(pulse_cnt), 32'd1);
        check("p1_hold", 32'(o_data), 32'h15A5A);

        // Second packet accumulates on top of the first
        send_pkt("p2", 20'h5A5A5, 20'h1FFFF);

        // Accumulator wraps modulo 2^16
        do_reset();
        send_pkt("wrap1", 20'hCFFFF, 20'h3FFFF);
        send_pkt("wrap2", 20'hC0002, 20'h30001);

        // Rise while busy is dropped
        do_reset();
        pulses_before = pulse_cnt;
        valid = 1'b1;
        data  = 20'h40001;
        step();
        valid = 1'b0;
        step();
        check("drop_resp_valid", 32'(o_valid), 32'd1);
        check("drop_resp_data", 32'(o_data), 32'h10001);
        valid = 1'b1;
        data  = 20'h40010;
        repeat (4) step();
        check("drop_single_pulse", 32'(pulse_cnt - pulses_before), 32'd1);
        check("drop_state_idle", 32'(dbg_state), 32'd0);
        valid = 1'b0;
        step();
        send_pkt("drop_acc", 20'h40002, 20'h10003);

        // Reset during COMPUTE loses the response
        pulses_before = pulse_cnt;
        valid = 1'b1;
        data  = 20'h41234;
        step();
        check("mid_state_compute", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_async_state", 32'(dbg_state), 32'd0);
        check("mid_async_data", 32'(o_data), 32'h00000);
        valid = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();
        check("mid_no_pulse", 32'(pulse_cnt - pulses_before), 32'd0);
        check("mid_data_zero", 32'(o_data), 32'h00000);
        send_pkt("mid_after", 20'h40001, 20'h10001);

        // Valid already high at reset release is accepted on the first edge
        rst   = 1'b1;
        valid = 1'b1;
        data  = 20'h40005;
        step();
        rst = 1'b0;
        step();
        check("rel_t0_state", 32'(dbg_state), 32'd1);
        step();
        check("rel_t1_valid", 32'(o_valid), 32'd1);
        check("rel_t1_data", 32'(o_data), 32'h10005);
        valid = 1'b0;
        step();
        check("rel_t2_valid", 32'(o_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
